// File: rtl/aes_pkg.sv
// Shared types and constants for the AES load controller slice.
// Optional feature macro used by the controller: AES_KEY_REUSE_EN.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_BLK   = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_OUT   = 3'd5
    } aes_ctrl_state_t;

    localparam int AES_KEY_BYTES        = 32;
    localparam int AES_BLK_BYTES        = 16;
    localparam int AES_CMD_LOAD_KEY_BIT = 0;

    // Counter values of the final byte in the KEY and BLK phases.
    localparam logic [4:0] KEY_LAST_CNT = 5'(AES_KEY_BYTES - 1);
    localparam logic [4:0] BLK_LAST_CNT = 5'(AES_BLK_BYTES - 1);

endpackage

// File: rtl/aes_byte_serializer.sv
// Loads a 128-bit word and emits it MSB byte first over a valid/ready port.
// done_o pulses together with the 16th accepted byte.
module aes_byte_serializer
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [127:0] load_data_i,
    output logic [7:0]   out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         done_o
);

    localparam logic [3:0] SER_LAST = 4'(AES_BLK_BYTES - 1);

    logic [127:0] sreg_q, sreg_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         vld_q, vld_d;
    logic         xfer;

    assign xfer        = vld_q & out_ready_i;
    assign done_o      = xfer & (cnt_q == SER_LAST);
    assign out_data_o  = sreg_q[127:120];
    assign out_valid_o = vld_q;

    // Next state: load wins, otherwise shift one byte per handshake.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        if (load_i) begin
            sreg_d = load_data_i;
            cnt_d  = 4'd0;
            vld_d  = 1'b1;
        end else if (xfer) begin
            sreg_d = {sreg_q[119:0], 8'h00};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == SER_LAST) begin
                vld_d = 1'b0;
            end
        end
    end

    // Shift register, byte counter and valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: rtl/aes_load_ctrl.sv
// Byte-stream sequencer between the host byte port and the AES-256 core:
// command byte, optional 32-byte key load, 16-byte block, core run, result out.
// Optional feature macro: AES_KEY_REUSE_EN (command bit0 = 0 reuses a stored key).
module aes_load_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   key_byte,
    output logic         key_valid,
    output logic [5:0]   key_byte_idx,
    output logic         key_last,
    input  logic         key_ready,
    output logic [127:0] core_block,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_result,
    output logic         busy
);

    aes_ctrl_state_t state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [7:0]      key_byte_q, key_byte_d;
    logic [5:0]      key_idx_q, key_idx_d;
    logic            key_valid_q, key_valid_d;
    logic            key_last_q, key_last_d;
    logic [127:0]    core_block_q, core_block_d;
    logic            in_xfer;
    logic            go_key;
    logic            ser_load;
    logic            ser_done;

    assign in_xfer = in_valid & in_ready;

`ifdef AES_KEY_REUSE_EN
    // A stored key is reused only when the host asks for it and one exists.
    assign go_key = in_data[AES_CMD_LOAD_KEY_BIT] | ~key_ready;
`else
    // Every transaction reloads the key; key_ready has no role here.
    logic unused_key_ready;
    assign unused_key_ready = key_ready;
    assign go_key           = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and byte-counter logic; the counter is cleared on each phase entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    state_d = go_key ? ST_KEY : ST_BLK;
                    cnt_d   = 5'd0;
                end
            end
            ST_KEY: begin
                if (in_xfer) begin
                    if (cnt_q == KEY_LAST_CNT) begin
                        state_d = ST_BLK;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_BLK: begin
                if (in_xfer) begin
                    if (cnt_q == BLK_LAST_CNT) begin
                        state_d = ST_START;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        in_ready   = 1'b0;
        core_start = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE, ST_KEY, ST_BLK: in_ready   = 1'b1;
            ST_START:                core_start = 1'b1;
            default:                 ;
        endcase
    end

    // Byte counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Key strobe next state: one pulse per accepted key byte, index is 1-based.
    always_comb begin
        key_valid_d = 1'b0;
        key_last_d  = 1'b0;
        key_byte_d  = key_byte_q;
        key_idx_d   = key_idx_q;
        if ((state_q == ST_KEY) && in_xfer) begin
            key_valid_d = 1'b1;
            key_byte_d  = in_data;
            key_idx_d   = {1'b0, cnt_q} + 6'd1;
            key_last_d  = (cnt_q == KEY_LAST_CNT);
        end
    end

    // Key strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
            key_last_q  <= 1'b0;
            key_byte_q  <= '0;
            key_idx_q   <= '0;
        end else begin
            key_valid_q <= key_valid_d;
            key_last_q  <= key_last_d;
            key_byte_q  <= key_byte_d;
            key_idx_q   <= key_idx_d;
        end
    end

    // Block assembly: byte n lands at [127-8n -: 8], i.e. slot (15-n) counted from the LSB.
    always_comb begin
        core_block_d = core_block_q;
        if ((state_q == ST_BLK) && in_xfer) begin
            core_block_d[{~cnt_q[3:0], 3'b000} +: 8] = in_data;
        end
    end

    // Block register; only written in BLK so it is stable through START/WAIT/OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_block_q <= '0;
        end else begin
            core_block_q <= core_block_d;
        end
    end

    // A core_done outside WAIT never reaches the serializer.
    assign ser_load = (state_q == ST_WAIT) & core_done;

    aes_byte_serializer u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (ser_load),
        .load_data_i (core_result),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .done_o      (ser_done)
    );

    assign key_byte     = key_byte_q;
    assign key_valid    = key_valid_q;
    assign key_byte_idx = key_idx_q;
    assign key_last     = key_last_q;
    assign core_block   = core_block_q;

endmodule

// File: tb/tb_aes_load_ctrl.sv
// Scoreboard bench for aes_load_ctrl: stimulus pushes expectations, a negedge
// monitor pops and compares key strobes, core blocks and result bytes.
`timescale 1ns/1ps
module tb_aes_load_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   key_byte;
    logic         key_valid;
    logic [5:0]   key_byte_idx;
    logic         key_last;
    logic         key_ready;
    logic [127:0] core_block;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_result;
    logic         busy;

    always #5 clk = ~clk;

    aes_load_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .key_byte     (key_byte),
        .key_valid    (key_valid),
        .key_byte_idx (key_byte_idx),
        .key_last     (key_last),
        .key_ready    (key_ready),
        .core_block   (core_block),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_result  (core_result),
        .busy         (busy)
    );

    typedef struct packed {
        logic [7:0] b;
        logic [5:0] idx;
        logic       last;
    } kexp_t;

    kexp_t        key_q[$];
    logic [127:0] blk_q[$];
    logic [7:0]   out_q[$];
    int           len_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference-model and monitor state.
    bit           key_stored;
    bit           gap_en, bp_en;
    int           acc, cur_len, out_cnt, txn_done_cnt, done_target;
    bit           key_due, start_due, idle_due, locked;
    bit           prev_ov, prev_or, prev_start;
    logic [7:0]   prev_od;
    bit           core_pend, stray_req;
    int           core_lat;
    logic [127:0] core_res;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Stand-in for the AES core: known vector, otherwise an arbitrary bijective mix.
    function automatic logic [127:0] core_model(input logic [127:0] b);
        if (b == 128'h00112233445566778899AABBCCDDEEFF)
            return 128'h8EA2B7CA516745BFEAFC49904B496089;
        return {b[60:0], b[127:61]} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    endfunction

    // Expected behaviour of one transaction, derived from the command rules.
    task automatic push_expect(input logic [7:0] cmd, input logic [255:0] key,
                               input logic [127:0] blk, output bit loads);
        logic [127:0] r;
`ifdef AES_KEY_REUSE_EN
        loads = cmd[0] || !key_stored;
`else
        loads = 1'b1;
        if (cmd[0]) loads = 1'b1;
`endif
        if (loads) begin
            for (int i = 0; i < 32; i++) begin
                key_q.push_back('{b: key[255-8*i -: 8], idx: 6'(i + 1), last: (i == 31)});
            end
            key_stored = 1'b1;
        end
        blk_q.push_back(blk);
        r = core_model(blk);
        for (int i = 0; i < 16; i++) out_q.push_back(r[127-8*i -: 8]);
        len_q.push_back(loads ? 49 : 17);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        if (gap_en && ($urandom_range(0, 1) == 1)) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            check("in_ready_timeout", 128'(0), 128'(1));
            summary_and_finish();
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] cmd, input logic [255:0] key,
                             input logic [127:0] blk, input bit loads, input bit skip_cmd);
        if (skip_cmd) in_valid = 1'b0;
        else          send_byte(cmd);
        if (loads) for (int i = 0; i < 32; i++) send_byte(key[255-8*i -: 8]);
        for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8]);
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 5000 && txn_done_cnt < target; c++) @(posedge clk);
        if (txn_done_cnt < target) begin
            check("txn_timeout", 128'(txn_done_cnt), 128'(target));
            summary_and_finish();
        end
        #1;
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [255:0] key, input logic [127:0] blk);
        bit loads;
        push_expect(cmd, key, blk, loads);
        send_body(cmd, key, blk, loads, 1'b0);
        done_target++;
        wait_done(done_target);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},   128'(in_ready),     128'(1));
        check({tag, "_out_valid"},  128'(out_valid),    128'(0));
        check({tag, "_out_data"},   128'(out_data),     128'(0));
        check({tag, "_key_valid"},  128'(key_valid),    128'(0));
        check({tag, "_key_byte"},   128'(key_byte),     128'(0));
        check({tag, "_key_idx"},    128'(key_byte_idx), 128'(0));
        check({tag, "_key_last"},   128'(key_last),     128'(0));
        check({tag, "_core_start"}, 128'(core_start),   128'(0));
        check({tag, "_core_block"}, core_block,         128'(0));
        check({tag, "_busy"},       128'(busy),         128'(0));
    endtask

    task automatic clear_model();
        key_q.delete(); blk_q.delete(); out_q.delete(); len_q.delete();
        acc = 0; cur_len = 0; out_cnt = 0;
        key_due = 0; start_due = 0; idle_due = 0; locked = 0;
        prev_ov = 0; prev_or = 0; prev_start = 0; prev_od = '0;
        core_pend = 0; key_ready = 1'b0; key_stored = 1'b0;
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Host-side backpressure on the result port.
    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Core stub: answers each start after a random latency; can also inject a stray done.
    always @(posedge clk) begin
        #1;
        core_done = 1'b0;
        if (stray_req) begin
            core_done   = 1'b1;
            core_result = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
            stray_req   = 1'b0;
        end else if (core_pend) begin
            if (core_lat == 0) begin
                core_done   = 1'b1;
                core_result = core_res;
                core_pend   = 1'b0;
            end else begin
                core_lat--;
            end
        end
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_due)   check("key_latency", 128'(key_valid), 128'(1));
            if (start_due) check("start_latency", 128'(core_start), 128'(1));
            key_due   = 0;
            start_due = 0;
            if (idle_due) begin
                check("idle_busy",      128'(busy),      128'(0));
                check("idle_in_ready",  128'(in_ready),  128'(1));
                check("idle_out_valid", 128'(out_valid), 128'(0));
                idle_due = 0;
                locked   = 0;
                txn_done_cnt++;
            end
            if (key_last && !key_valid) check("key_last_alone", 128'(1), 128'(0));
            if (key_valid) begin
                if (key_q.size() == 0) begin
                    check("unexpected_key_valid", 128'(1), 128'(0));
                end else begin
                    kexp_t e;
                    e = key_q.pop_front();
                    check("key_byte", 128'(key_byte),     128'(e.b));
                    check("key_idx",  128'(key_byte_idx), 128'(e.idx));
                    check("key_last", 128'(key_last),     128'(e.last));
                end
                if (key_last) key_ready = 1'b1;
            end
            if (core_start) begin
                check("start_one_cycle", 128'(prev_start), 128'(0));
                if (blk_q.size() == 0) begin
                    check("unexpected_core_start", 128'(1), 128'(0));
                end else begin
                    check("core_block", core_block, blk_q.pop_front());
                end
                core_res  = core_model(core_block);
                core_lat  = $urandom_range(0, 4);
                core_pend = 1'b1;
                locked    = 1;
            end
            if (locked) check("in_ready_locked", 128'(in_ready), 128'(0));
            if (prev_ov && !prev_or) begin
                check("stall_valid", 128'(out_valid), 128'(1));
                check("stall_data",  128'(out_data),  128'(prev_od));
            end
            if (in_valid && in_ready) begin
                if (acc == 0) begin
                    if (len_q.size() == 0) begin
                        check("unexpected_in_byte", 128'(1), 128'(0));
                        cur_len = 1;
                    end else begin
                        cur_len = len_q.pop_front();
                    end
                end
                acc++;
                if (cur_len == 49 && acc >= 2 && acc <= 33) key_due = 1;
                if (acc == cur_len) begin
                    start_due = 1;
                    acc       = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    check("unexpected_out_byte", 128'(out_data), 128'(0));
                end else begin
                    check("out_data", 128'(out_data), 128'(out_q.pop_front()));
                end
                out_cnt++;
                if (out_cnt == 16) begin
                    out_cnt  = 0;
                    idle_due = 1;
                end
            end else if (out_valid && out_q.size() == 0 && !locked) begin
                check("stray_out_valid", 128'(out_valid), 128'(0));
            end
            prev_ov    = out_valid;
            prev_or    = out_ready;
            prev_od    = out_data;
            prev_start = core_start;
        end
    end

    initial begin
        logic [255:0] k, kb;
        logic [127:0] b, bb;
        bit           la, lb;

        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        core_done = 1'b0; core_result = '0; stray_req = 1'b0;
        gap_en = 0; bp_en = 0; txn_done_cnt = 0; done_target = 0;
        clear_model();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known-answer transaction.
        for (int i = 0; i < 32; i++) k[255-8*i -: 8] = 8'(i);
        run_txn(8'h01, k, 128'h00112233445566778899AABBCCDDEEFF);

        // Random gaps and result backpressure.
        gap_en = 1; bp_en = 1;
        for (int t = 0; t < 4; t++) run_txn(8'($urandom), rand_key(), rand_blk());
        gap_en = 0; bp_en = 0;

        // Command 0x00 after a completed key load.
        run_txn(8'h00, rand_key(), rand_blk());

        // in_valid held high through START/WAIT/OUT; the held byte becomes the next command.
        k = rand_key(); b = rand_blk(); kb = rand_key(); bb = rand_blk();
        push_expect(8'h01, k, b, la);
        send_body(8'h01, k, b, la, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h01;
        push_expect(8'h01, kb, bb, lb);
        done_target++;
        wait_done(done_target);
        send_body(8'h01, kb, bb, lb, 1'b1);
        done_target++;
        wait_done(done_target);

        // Asynchronous reset after 20 key bytes.
        k = rand_key(); b = rand_blk();
        push_expect(8'h01, k, b, la);
        send_byte(8'h01);
        for (int i = 0; i < 20; i++) send_byte(k[255-8*i -: 8]);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset("mid_rst");
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        stray_req = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("stray_done_out_valid", 128'(out_valid), 128'(0));
        check("stray_done_busy",      128'(busy),      128'(0));

        // Fresh transaction after reset restarts the key at index 1.
        run_txn(8'h00, rand_key(), rand_blk());

        check("leftover_key_exp", 128'(key_q.size()), 128'(0));
        check("leftover_out_exp", 128'(out_q.size()), 128'(0));
        summary_and_finish();
    end

endmodule
